// File: rtl/lo_monitor.sv
// LO drive-pair monitor: synchronizes lo_p/lo_n, counts lo_p rising edges over a gated window, flags overlap/gap faults.
// Optional macro LO_MON_PERIOD_EN adds shortest rise-to-rise interval tracking on period_min.
module lo_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FAULT_LEN   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lo_p,
    input  logic             lo_n,
    input  logic             start,
    input  logic [1:0]       window_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_count,
    output logic             overflow,
    output logic             overlap_err,
    output logic             gap_err,
    output logic [CNT_W-1:0] period_min
);
    localparam int WIN_W = 14;
    localparam int RUN_W = $clog2(FAULT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FAULT_LEN);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] p_sync_q, p_sync_d, n_sync_q, n_sync_d;
    logic                   p_prev_q, p_prev_d;
    logic [1:0]             sel_q, sel_d;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [RUN_W-1:0]       run_q, run_d;
    logic                   ovl_q, ovl_d, gap_q, gap_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0]       edge_count_q, edge_count_d;
    logic                   overflow_q, overflow_d;
    logic                   overlap_err_q, overlap_err_d, gap_err_q, gap_err_d;
    logic                   sp, sn, rise;

    assign sp   = p_sync_q[SYNC_STAGES-1];
    assign sn   = n_sync_q[SYNC_STAGES-1];
    assign rise = sp && !p_prev_q;

    always_comb begin
        p_sync_d      = {p_sync_q[SYNC_STAGES-2:0], lo_p};
        n_sync_d      = {n_sync_q[SYNC_STAGES-2:0], lo_n};
        p_prev_d      = sp;
        state_d       = state_q;
        sel_d         = sel_q;
        win_d         = win_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        run_d         = run_q;
        ovl_d         = ovl_q;
        gap_d         = gap_q;
        done_d        = 1'b0;
        edge_count_d  = edge_count_q;
        overflow_d    = overflow_q;
        overlap_err_d = overlap_err_q;
        gap_err_d     = gap_err_q;
        case (state_q)
            IDLE: begin
                // busy_q is still high for the cycle after done, so a start there is dropped
                if (start && !busy_q) begin
                    state_d = ARM;
                    sel_d   = window_sel;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    run_d   = '0;
                    ovl_d   = 1'b0;
                    gap_d   = 1'b0;
                end
            end
            ARM: begin
                state_d = MEASURE;
                win_d   = WIN_W'((32'd1 << (32'd8 + 32'(sel_q) * 32'd2)) - 32'd1);
            end
            MEASURE: begin
                if (rise) begin
                    if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                    else                  cnt_d = cnt_q + 1'b1;
                end
                if (sp == sn) begin
                    if (run_q != RUN_MAX) run_d = run_q + 1'b1;
                    if (run_d == RUN_MAX) begin
                        if (sp) ovl_d = 1'b1;
                        else    gap_d = 1'b1;
                    end
                end else begin
                    run_d = '0;
                end
                if (win_q == '0) state_d = DONE;
                else             win_d   = win_q - 1'b1;
            end
            DONE: begin
                state_d       = IDLE;
                done_d        = 1'b1;
                edge_count_d  = cnt_q;
                overflow_d    = ovf_q;
                overlap_err_d = ovl_q;
                gap_err_d     = gap_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            p_sync_q      <= '0;
            n_sync_q      <= '0;
            p_prev_q      <= 1'b0;
            sel_q         <= '0;
            win_q         <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            run_q         <= '0;
            ovl_q         <= 1'b0;
            gap_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            edge_count_q  <= '0;
            overflow_q    <= 1'b0;
            overlap_err_q <= 1'b0;
            gap_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_sync_q      <= p_sync_d;
            n_sync_q      <= n_sync_d;
            p_prev_q      <= p_prev_d;
            sel_q         <= sel_d;
            win_q         <= win_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            run_q         <= run_d;
            ovl_q         <= ovl_d;
            gap_q         <= gap_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            edge_count_q  <= edge_count_d;
            overflow_q    <= overflow_d;
            overlap_err_q <= overlap_err_d;
            gap_err_q     <= gap_err_d;
        end
    end

`ifdef LO_MON_PERIOD_EN
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d, per_min_q, per_min_d, period_min_q, period_min_d;
    logic             seen_q, seen_d;

    // per_cnt holds cycles since the last synced rise, so at the next rise it equals the interval
    always_comb begin
        per_cnt_d    = per_cnt_q;
        per_min_d    = per_min_q;
        seen_d       = seen_q;
        period_min_d = period_min_q;
        if (state_q == ARM) begin
            per_cnt_d = '0;
            per_min_d = '1;
            seen_d    = 1'b0;
        end else if (state_q == MEASURE) begin
            if (rise) begin
                if (seen_q && per_cnt_q < per_min_q) per_min_d = per_cnt_q;
                per_cnt_d = CNT_W'(1);
                seen_d    = 1'b1;
            end else if (per_cnt_q != CNT_MAX) begin
                per_cnt_d = per_cnt_q + 1'b1;
            end
        end else if (state_q == DONE) begin
            period_min_d = per_min_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q    <= '0;
            per_min_q    <= '0;
            seen_q       <= 1'b0;
            period_min_q <= '0;
        end else begin
            per_cnt_q    <= per_cnt_d;
            per_min_q    <= per_min_d;
            seen_q       <= seen_d;
            period_min_q <= period_min_d;
        end
    end

    assign period_min = period_min_q;
`else
    assign period_min = '0;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign edge_count  = edge_count_q;
    assign overflow    = overflow_q;
    assign overlap_err = overlap_err_q;
    assign gap_err     = gap_err_q;
endmodule

// File: tb/tb_lo_monitor.sv
// Self-checking bench for lo_monitor: LO waveform generator, recorded history and a window-level reference model.
module tb_lo_monitor;
    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
    localparam int FLEN  = 2;
    localparam int HMAX  = 1 << 17;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0, rst_n = 1'b0, lo_p = 1'b0, lo_n = 1'b1, start = 1'b0;
    logic [1:0]       window_sel = 2'd0;
    logic             busy, done, overflow, overlap_err, gap_err;
    logic [CNT_W-1:0] edge_count, period_min;

    lo_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .FAULT_LEN(FLEN)) dut (
        .clk(clk), .rst_n(rst_n), .lo_p(lo_p), .lo_n(lo_n), .start(start),
        .window_sel(window_sel), .busy(busy), .done(done), .edge_count(edge_count),
        .overflow(overflow), .overlap_err(overlap_err), .gap_err(gap_err),
        .period_min(period_min)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    bit hp[HMAX];
    bit hn[HMAX];
    int per_q[$];
    int base_per = 8, cur_per = 8, ph = 0;
    int f_cyc = -1, f_type = 0, f_len = 0, f_left = 0;
    int nchk = 0, npass = 0;

    // LO source: complementary square wave, optional forced both-high/both-low burst
    always @(posedge clk) begin
        cyc++;
        #1;
        if (ph == 0) cur_per = (per_q.size() > 0) ? per_q.pop_front() : base_per;
        lo_p = (ph < cur_per / 2);
        lo_n = !lo_p;
        ph   = (ph + 1 == cur_per) ? 0 : ph + 1;
        if (cyc == f_cyc) f_left = f_len;
        if (f_left > 0) begin
            lo_p = (f_type == 1);
            lo_n = lo_p;
            f_left--;
        end
        hp[cyc] = lo_p;
        hn[cyc] = lo_n;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Window sample i is the LO value driven SYNC+1 cycles before the i-th measuring edge
    task automatic model(input int cs, input int len, output int ec, output int ov,
                         output int ol, output int gp, output int pm);
        int rises = 0, last = -1, run = 0;
        ol = 0; gp = 0; pm = CMAX;
        for (int i = 0; i < len; i++) begin
            int s = cs + 1 - SYNC + i;
            if (hp[s] && !hp[s-1]) begin
                rises++;
                if (last >= 0 && i - last < pm) pm = i - last;
                last = i;
            end
            if (hp[s] == hn[s]) begin
                run++;
                if (run >= FLEN) begin
                    if (hp[s]) ol = 1;
                    else       gp = 1;
                end
            end else run = 0;
        end
        ec = (rises > CMAX) ? CMAX : rises;
        ov = (rises > CMAX) ? 1 : 0;
    endtask

    int r_ec, r_ov, r_ol, r_gp, r_pm;

    // One measurement; optional burst and mid-window start/window_sel churn
    task automatic measure(input string tag, input int sel, input int ftype, input int flen,
                           input int fidx, input bit churn);
        int len, cs, lat, extra;
        len = 1 << (8 + 2 * sel);
        window_sel = 2'(sel);
        if (ftype != 0) begin
            f_type = ftype; f_len = flen;
            f_cyc = cyc + 1 + 1 - SYNC + fidx;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cs = cyc;
        lat = 0;
        while (!done && lat < len + 50) begin
            start = churn && (lat == 50);
            if (churn && lat == 50) window_sel = 2'(3 - sel);
            @(posedge clk); #1;
            lat = cyc - cs;
        end
        start = 1'b0;
        chk({tag, ".latency"}, lat, len + 2);
        chk({tag, ".busy_at_done"}, int'(busy), 1);
        model(cs, len, r_ec, r_ov, r_ol, r_gp, r_pm);
        chk({tag, ".edge_count"}, int'(edge_count), r_ec);
        chk({tag, ".overflow"}, int'(overflow), r_ov);
        chk({tag, ".overlap"}, int'(overlap_err), r_ol);
        chk({tag, ".gap"}, int'(gap_err), r_gp);
`ifdef LO_MON_PERIOD_EN
        chk({tag, ".period_min"}, int'(period_min), r_pm);
`else
        chk({tag, ".period_min"}, int'(period_min), 0);
`endif
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, int'(done), 0);
        chk({tag, ".busy_fall"}, int'(busy), 0);
        if (churn) begin
            extra = 0;
            for (int k = 0; k < 300; k++) begin
                @(posedge clk); #1;
                if (done) extra++;
            end
            chk({tag, ".single_done"}, extra, 0);
        end
        f_cyc = -1;
        window_sel = 2'd0;
    endtask

    initial begin
        int dcnt, sel, ft;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.edge_count", int'(edge_count), 0);
        chk("rst.overflow", int'(overflow), 0);
        chk("rst.overlap", int'(overlap_err), 0);
        chk("rst.gap", int'(gap_err), 0);
        chk("rst.period_min", int'(period_min), 0);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        base_per = 8;
        measure("p8_sel0", 0, 0, 0, 0, 1'b0);
        chk("p8_sel0.const", int'(edge_count), 32);
        base_per = 16;
        repeat (20) @(posedge clk);
        #1;
        measure("p16_sel1", 1, 0, 0, 0, 1'b0);
        chk("p16_sel1.const", int'(edge_count), 64);
        measure("p16_sel3", 3, 0, 0, 0, 1'b0);
        chk("p16_sel3.sat", int'(edge_count), CMAX);
        base_per = 4;
        repeat (20) @(posedge clk);
        #1;
        measure("ovf", 1, 0, 0, 0, 1'b0);
        chk("ovf.const_cnt", int'(edge_count), 255);
        chk("ovf.const_flag", int'(overflow), 1);

        base_per = 8;
        repeat (20) @(posedge clk);
        #1;
        measure("overlap3", 0, 1, 3, 100, 1'b0);
        chk("overlap3.const_ovl", int'(overlap_err), 1);
        chk("overlap3.const_gap", int'(gap_err), 0);
        measure("gap1", 0, 2, 1, 120, 1'b0);
        chk("gap1.const_gap", int'(gap_err), 0);
        chk("gap1.const_ovl", int'(overlap_err), 0);

        measure("churn", 0, 0, 0, 0, 1'b1);

        for (int k = 0; k < 5; k++) per_q.push_back(10);
        for (int k = 0; k < 5; k++) per_q.push_back(6);
        measure("period", 0, 0, 0, 0, 1'b0);
`ifdef LO_MON_PERIOD_EN
        chk("period.const", int'(period_min), 6);
`else
        chk("period.const", int'(period_min), 0);
`endif

        for (int it = 0; it < 6; it++) begin
            base_per = int'($urandom_range(4, 20));
            sel = int'($urandom_range(0, 2));
            ft = int'($urandom_range(0, 2));
            repeat (int'($urandom_range(3, 30))) @(posedge clk);
            #1;
            measure($sformatf("rnd%0d", it), sel, ft, int'($urandom_range(1, 3)),
                    int'($urandom_range(10, 200)), 1'b0);
        end

        base_per = 8;
        window_sel = 2'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort.busy", int'(busy), 0);
        chk("abort.done", int'(done), 0);
        chk("abort.edge_count", int'(edge_count), 0);
        chk("abort.overflow", int'(overflow), 0);
        chk("abort.overlap", int'(overlap_err), 0);
        chk("abort.gap", int'(gap_err), 0);
        chk("abort.period_min", int'(period_min), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 1100; k++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        chk("abort.no_done", dcnt, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
